// File: rtl/mb_reader.sv
// ---------------------------------------------------------------------------
// mb_reader
// Walks a frame one macroblock at a time. For each macroblock it reads 96
// words (64 Y, 16 U, 16 V) from memory. It keeps at most MAX_OUTSTANDING
// reads in flight and forwards each returned word downstream. It then waits
// until the consumer has taken the macroblock before moving to the next one.
//
// Optional feature:
//   `define MB_READER_ERR_CHK_EN  -> sticky err_o on a response with no read
//                                    outstanding, or on frame_start_i while
//                                    busy. Without it, err_o is tied to 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_start_i     start-of-frame pulse (ignored while busy_o)
//   mem_req_o         read request, held with stable address until mem_gnt_i
//   mem_addr_o        word address of the current request (0 when idle)
//   mem_gnt_i         request accepted this cycle
//   mem_rvalid_i      in-order read response valid
//   mem_rdata_i       read response data
//   fetch_start_o     one-cycle pulse at the start of each macroblock load
//   data_word_o       forwarded read word (registered)
//   data_valid_o      data_word_o valid (registered)
//   fetch_valid_i     downstream holds a complete macroblock
//   intra_ready_i     intra stage ready to take the macroblock
//   mb_x_o, mb_y_o    current macroblock column / row
//   busy_o            frame in progress
//   frame_done_o      one-cycle pulse after the last macroblock
//   err_o             sticky protocol error
// ---------------------------------------------------------------------------
module mb_reader #(
  parameter int          FRAME_MB_W      = 22,
  parameter int          FRAME_MB_H      = 18,
  parameter logic [31:0] BASE_ADDR       = 32'd0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fetch_start_o,
  output logic [31:0] data_word_o,
  output logic        data_valid_o,
  input  logic        fetch_valid_i,
  input  logic        intra_ready_i,
  output logic [5:0]  mb_x_o,
  output logic [5:0]  mb_y_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_WAIT_CONS = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;

  localparam logic [6:0]  WORDS_PER_MB = 7'd96;
  localparam logic [6:0]  MAX_OUT      = 7'(MAX_OUTSTANDING);
  localparam logic [31:0] LAST_X       = 32'(FRAME_MB_W - 1);
  localparam logic [31:0] LAST_Y       = 32'(FRAME_MB_H - 1);

  logic [2:0]  state_reg, state_next;
  logic [6:0]  req_cnt_reg, req_cnt_next;
  logic [6:0]  rsp_cnt_reg, rsp_cnt_next;
  logic [5:0]  mb_x_reg, mb_x_next;
  logic [5:0]  mb_y_reg, mb_y_next;
  logic [31:0] data_word_reg;
  logic        data_valid_reg;

  logic [6:0]  outstanding;
  logic        grant;
  logic        rsp_accept;
  logic        last_col;
  logic        last_row;
  logic [31:0] mb_index;

  // Responses never outnumber requests, so this difference cannot underflow.
  assign outstanding = req_cnt_reg - rsp_cnt_reg;

  // The request depends only on registered state. A grant is the only thing
  // that can raise req_cnt, so once raised the request stays up (and its
  // address stays put) until it is granted.
  assign mem_req_o = (state_reg == S_REQ) && (req_cnt_reg < WORDS_PER_MB) &&
                     (outstanding < MAX_OUT);
  assign grant     = mem_req_o && mem_gnt_i;

  // Responses count only while a load is active and still short of 96.
  // Anything else is a stray and is dropped.
  assign rsp_accept = mem_rvalid_i && (rsp_cnt_reg < WORDS_PER_MB) &&
                      ((state_reg == S_REQ) || (state_reg == S_DRAIN));

  assign mb_index   = 32'(mb_y_reg) * 32'(FRAME_MB_W) + 32'(mb_x_reg);
  // The address is gated so that it reads 0 whenever no request is up.
  assign mem_addr_o = mem_req_o ? (BASE_ADDR + mb_index * 32'd96 + 32'(req_cnt_reg))
                                : 32'd0;

  assign last_col = {26'd0, mb_x_reg} >= LAST_X;
  assign last_row = {26'd0, mb_y_reg} >= LAST_Y;

  always_comb begin
    state_next   = state_reg;
    req_cnt_next = req_cnt_reg;
    rsp_cnt_next = rsp_cnt_reg;
    mb_x_next    = mb_x_reg;
    mb_y_next    = mb_y_reg;

    // A grant and a response in the same cycle are both counted.
    if (grant)      req_cnt_next = req_cnt_reg + 7'd1;
    if (rsp_accept) rsp_cnt_next = rsp_cnt_reg + 7'd1;

    case (state_reg)
      S_IDLE: begin
        if (frame_start_i) begin
          state_next = S_START;
          mb_x_next  = 6'd0;
          mb_y_next  = 6'd0;
        end
      end
      S_START: begin
        req_cnt_next = 7'd0;
        rsp_cnt_next = 7'd0;
        state_next   = S_REQ;
      end
      S_REQ: begin
        if (req_cnt_next == WORDS_PER_MB) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (rsp_cnt_reg == WORDS_PER_MB) state_next = S_WAIT_CONS;
      end
      S_WAIT_CONS: begin
        if (fetch_valid_i && intra_ready_i) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (!last_col) begin
          mb_x_next  = mb_x_reg + 6'd1;
          state_next = S_START;
        end else if (!last_row) begin
          mb_x_next  = 6'd0;
          mb_y_next  = mb_y_reg + 6'd1;
          state_next = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      req_cnt_reg    <= 7'd0;
      rsp_cnt_reg    <= 7'd0;
      mb_x_reg       <= 6'd0;
      mb_y_reg       <= 6'd0;
      data_word_reg  <= 32'd0;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_cnt_reg    <= req_cnt_next;
      rsp_cnt_reg    <= rsp_cnt_next;
      mb_x_reg       <= mb_x_next;
      mb_y_reg       <= mb_y_next;
      data_valid_reg <= rsp_accept;
      if (rsp_accept) data_word_reg <= mem_rdata_i;
    end
  end

  assign fetch_start_o = (state_reg == S_START);
  assign busy_o        = (state_reg != S_IDLE);
  assign frame_done_o  = (state_reg == S_NEXT) && last_col && last_row;
  assign mb_x_o        = mb_x_reg;
  assign mb_y_o        = mb_y_reg;
  assign data_word_o   = data_word_reg;
  assign data_valid_o  = data_valid_reg;

`ifdef MB_READER_ERR_CHK_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((mem_rvalid_i && (outstanding == 7'd0)) ||
                 (frame_start_i && busy_o)) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/mb_reader.md
MB_READER -- requirements
Module: mb_reader

Interface
REQ-001 SHALL have parameters: FRAME_MB_W, default 22, macroblocks per row; FRAME_MB_H, default 18, macroblock rows per frame; BASE_ADDR, default 32'd0, frame base word address; MAX_OUTSTANDING, default 4, range 1..8, read requests in flight.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start_i  in  1  start-of-frame pulse.
- mem_req_o  out  1  read request.
- mem_addr_o  out  32  word address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; responses return in order, any latency >= 1.
- mem_rdata_i  in  32  read data.
- fetch_start_o  out  1  one-cycle pulse that starts the downstream macroblock load.
- data_word_o  out  32  word to the downstream fetch stage.
- data_valid_o  out  1  word valid.
- fetch_valid_i  in  1  downstream holds a complete macroblock.
- intra_ready_i  in  1  intra stage is ready to take the macroblock.
- mb_x_o  out  6  current macroblock column.
- mb_y_o  out  6  current macroblock row.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse after the last macroblock.
- err_o  out  1  sticky protocol error.

Function
REQ-004 States: IDLE, START, REQ, DRAIN, WAIT_CONS, NEXT.
REQ-005 IDLE -> START on frame_start_i; mb_x and mb_y are cleared to 0 at this transition.
REQ-006 START: fetch_start_o = 1 for exactly 1 cycle; req_cnt and rsp_cnt are cleared; next state is REQ.
REQ-007 REQ: mem_req_o = 1 while req_cnt < 96 and (req_cnt - rsp_cnt) < MAX_OUTSTANDING.
- mem_req_o, when asserted, SHALL stay high with a stable address until mem_gnt_i.
- req_cnt increments on mem_req_o && mem_gnt_i.
- Next state is DRAIN when req_cnt reaches 96.
REQ-008 mem_addr_o = BASE_ADDR + (mb_y*FRAME_MB_W + mb_x)*96 + req_cnt, in 32-bit arithmetic, wrapping modulo 2^32.
- The 96 words per macroblock are laid out as 64 Y words, then 16 U words, then 16 V words.
REQ-009 Each mem_rvalid_i in REQ or DRAIN increments rsp_cnt.
- The word is forwarded as data_word_o = mem_rdata_i and data_valid_o = 1, registered, with 1 cycle latency.
REQ-010 DRAIN -> WAIT_CONS when rsp_cnt reaches 96. Responses beyond 96, or received in IDLE, START, WAIT_CONS or NEXT, SHALL be dropped (data_valid_o stays 0).
REQ-011 WAIT_CONS -> NEXT when fetch_valid_i && intra_ready_i in the same cycle; no memory requests are issued in WAIT_CONS.
REQ-012 NEXT advances the macroblock position:
- If mb_x < FRAME_MB_W-1: mb_x++, then go to START.
- Else if mb_y < FRAME_MB_H-1: mb_x = 0, mb_y++, then go to START.
- Else: frame_done_o = 1 for one cycle, then go to IDLE.
REQ-013 busy_o = 1 in every state except IDLE.
REQ-014 frame_start_i while busy_o = 1 SHALL be ignored.
REQ-015 A grant and a response in the same cycle SHALL both be counted; the outstanding count is req_cnt - rsp_cnt.

Reset
REQ-016 Assertion of rst_n = 0 SHALL immediately force:
- state IDLE;
- all counters 0;
- mb_x_o, mb_y_o = 0;
- mem_req_o, fetch_start_o, data_valid_o, busy_o, frame_done_o, err_o = 0;
- mem_addr_o, data_word_o = 0.
REQ-017 Reset mid-frame SHALL abandon the frame. Responses to requests granted before reset SHALL be dropped per REQ-010.

Configuration
REQ-018 Macro MB_READER_ERR_CHK_EN:
- Defined: err_o is set, and held until reset, on either of:
  - mem_rvalid_i with zero outstanding requests;
  - frame_start_i while busy_o = 1.
- Undefined: err_o is constant 0 and the checking logic is absent.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-019 Reset: drive rst_n = 0 asynchronously mid-cycle -> all outputs 0 before the next clk edge.
REQ-020 FRAME_MB_W=2, FRAME_MB_H=2, grant always 1, 1-cycle memory, consumer always ready:
- 4 fetch_start_o pulses at (0,0), (1,0), (0,1), (1,1);
- addresses 0..383 in order;
- 384 data_valid_o words matching memory;
- 1 frame_done_o pulse, then busy_o = 0.
REQ-021 MAX_OUTSTANDING=4, grant always 1, response latency 10 cycles -> outstanding count never exceeds 4; all 96 words delivered in order.
REQ-022 intra_ready_i held low for 50 cycles after a macroblock is loaded -> state stays WAIT_CONS, mem_req_o = 0, mb_x_o unchanged; advance occurs 1 cycle after intra_ready_i rises.
REQ-023 Reset asserted after 40 grants, then 3 stray mem_rvalid_i in IDLE -> data_valid_o stays 0; next frame_start_i restarts at address BASE_ADDR.
REQ-024 mem_rvalid_i while idle -> err_o = 1 with MB_READER_ERR_CHK_EN defined; err_o = 0 without it.
